// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA display engine: pixel-source modes,
// config word layout, LFSR seed/taps and the pending-slot state encoding.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_NOISE = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_MASK  = 2'd2,
        MODE_BARS  = 2'd3
    } mode_e;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_e;

    typedef struct packed {
        mode_e       mode;
        logic [11:0] color_a;
        logic [11:0] color_b;
    } cfg_t;

    localparam int CFG_WIDTH       = 32;
    localparam int CFG_MODE_LSB    = 30;
    localparam int CFG_COLOR_A_LSB = 12;
    localparam int CFG_COLOR_B_LSB = 0;

    localparam cfg_t CFG_RESET = '{mode: MODE_MASK, color_a: 12'hFFF, color_b: 12'h000};

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting towards the MSB.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic cfg_t unpack_cfg(input logic [CFG_WIDTH-1:0] w);
        cfg_t c;
        c.mode    = mode_e'(w[CFG_MODE_LSB +: 2]);
        c.color_a = w[CFG_COLOR_A_LSB +: 12];
        c.color_b = w[CFG_COLOR_B_LSB +: 12];
        return c;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vga_display_engine_if.sv
// Config handshake between the SPI-side config source (master) and the
// display engine (slave).
interface vga_display_engine_if;
    import vga_pkg::*;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CFG_WIDTH-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/vga_timing_core.sv
// Raster counters with stage-0 visible/sync flags and the end-of-frame
// commit strobe.
module vga_timing_core #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       vis,
    output logic       hs0,
    output logic       vs0,
    output logic       commit
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
    end

    always_comb begin
        vis    = (x_q < H_VIS) && (y_q < V_VIS);
        hs0    = ((x_q >= HS_START) && (x_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs0    = ((y_q >= VS_START) && (y_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
        commit = (x_q == H_LAST) && (y_q == V_LAST);
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/vga_display_engine.sv
// VGA display engine: timing core, 4-mode pixel source, tear-free config
// register committed at the frame boundary, and the stage-1 pin registers.
module vga_display_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int COLOR_BITS = 2,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    vga_display_engine_if.slave     cfg,
    input  logic                    pixel_mask,
    output logic [9:0]              x,
    output logic [9:0]              y,
    output logic                    hs,
    output logic                    vs,
    output logic                    active,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic                    frame_start,
    output logic [7:0]              frame_cnt
);
    localparam int RGB_W = 3 * COLOR_BITS;

    logic vis, hs0, vs0, commit;

    vga_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .y      (y),
        .vis    (vis),
        .hs0    (hs0),
        .vs0    (vs0),
        .commit (commit)
    );

    pend_state_e       pend_state_q, pend_state_d;
    cfg_t              pend_q, pend_d;
    cfg_t              cfg_q, cfg_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              frame_start_q, frame_start_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              active_q, active_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              cfg_ready_int;
    logic              cfg_accept;

    // Pending slot FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_state_q <= PEND_EMPTY;
        else     pend_state_q <= pend_state_d;
    end

    // Pending slot FSM: next state
    always_comb begin
        pend_state_d = pend_state_q;
        case (pend_state_q)
            PEND_EMPTY: if (cfg_accept) pend_state_d = PEND_FULL;
            PEND_FULL:  if (commit)     pend_state_d = PEND_EMPTY;
            default:                    pend_state_d = PEND_EMPTY;
        endcase
    end

    // Pending slot FSM: outputs
    always_comb begin
        cfg_ready_int = (pend_state_q == PEND_EMPTY);
    end

    assign cfg_accept    = cfg.cfg_valid && cfg_ready_int;
    assign cfg.cfg_ready = cfg_ready_int;

    // Per-channel colour slices: channel 0 is blue (low nibble / low rgb bits).
    logic [RGB_W-1:0] color_a_px, color_b_px, bars_px;
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign color_a_px[gi*COLOR_BITS +: COLOR_BITS] = cfg_q.color_a[gi*4+3 -: COLOR_BITS];
        assign color_b_px[gi*COLOR_BITS +: COLOR_BITS] = cfg_q.color_b[gi*4+3 -: COLOR_BITS];
        assign bars_px[gi*COLOR_BITS +: COLOR_BITS]    = {COLOR_BITS{x[6+gi]}};
    end

    logic [RGB_W-1:0] pixel;

    always_comb begin
        pixel = '0;
        case (cfg_q.mode)
            MODE_NOISE: pixel = lfsr_q[RGB_W-1:0];
            MODE_SOLID: pixel = color_a_px;
            MODE_MASK:  pixel = pixel_mask ? color_a_px : color_b_px;
            MODE_BARS:  pixel = bars_px;
            default:    pixel = '0;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        if (cfg_accept) pend_d = unpack_cfg(cfg.cfg_data);

        // A word accepted on the commit cycle is still empty here, so it waits a frame.
        cfg_d = cfg_q;
        if (commit && (pend_state_q == PEND_FULL)) cfg_d = pend_q;

        frame_cnt_d   = commit ? frame_cnt_q + 8'd1 : frame_cnt_q;
        frame_start_d = commit;
        lfsr_d        = lfsr_step(lfsr_q);

        hs_d     = hs0;
        vs_d     = vs0;
        active_d = vis;
        rgb_d    = vis ? pixel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q        <= '0;
            cfg_q         <= CFG_RESET;
            lfsr_q        <= LFSR_SEED;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            active_q      <= 1'b0;
            rgb_q         <= '0;
        end else begin
            pend_q        <= pend_d;
            cfg_q         <= cfg_d;
            lfsr_q        <= lfsr_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            active_q      <= active_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign active      = active_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_display_engine.sv
// Directed bench for vga_display_engine on a shrunken raster, plus a tiny
// second instance used to reach the 255->0 frame counter wrap quickly.
`timescale 1ns/1ps
module tb_vga_display_engine;
    localparam int H_ACTIVE = 512, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 2,   V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int H_TOTAL  = 528;
    localparam int V_TOTAL  = 5;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_w, pixel_mask, pixel_mask_w;
    logic [9:0] x, y, x_w, y_w;
    logic       hs, vs, active, frame_start;
    logic       hs_w, vs_w, active_w, frame_start_w;
    logic [5:0] rgb;
    logic [2:0] rgb_w;
    logic [7:0] frame_cnt, frame_cnt_w;

    vga_display_engine_if cfg_if();
    vga_display_engine_if cfg_if_w();

    vga_display_engine #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .COLOR_BITS(2), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .cfg(cfg_if), .pixel_mask(pixel_mask),
        .x(x), .y(y), .hs(hs), .vs(vs), .active(active), .rgb(rgb),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    // 16x8 raster = 128 clocks per frame, inverted sync polarity, 1 bit per channel.
    vga_display_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .COLOR_BITS(1), .SYNC_POL(1'b1)
    ) dut_w (
        .clk(clk), .rst(rst_w), .cfg(cfg_if_w), .pixel_mask(pixel_mask_w),
        .x(x_w), .y(y_w), .hs(hs_w), .vs(vs_w), .active(active_w), .rgb(rgb_w),
        .frame_start(frame_start_w), .frame_cnt(frame_cnt_w)
    );

    int checks = 0;
    int errors = 0;

    // Reference clock count since reset release and reference LFSR.
    int          cyc;
    logic [15:0] lfsr_ref, lfsr_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc       <= 0;
            lfsr_ref  <= 16'hACE1;
            lfsr_prev <= 16'hACE1;
        end else begin
            cyc       <= cyc + 1;
            lfsr_prev <= lfsr_ref;
            lfsr_ref  <= {lfsr_ref[14:0], lfsr_ref[15] ^ lfsr_ref[13] ^ lfsr_ref[12] ^ lfsr_ref[10]};
        end
    end

    // At a falling edge the pins show raster position cyc-1, x/y show position cyc.
    task automatic goto_phase(input int ph);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (((cyc % FRAME) != ph) && (guard < 2 * FRAME));
    endtask

    task automatic offer(input logic [31:0] w);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = w;
        $display("cfg word %08h offered at phase %0d", w, cyc % FRAME);
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_w = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (x !== 10'd0 || y !== 10'd0) begin errors++; $display("FAIL reset_xy: got x=%0d y=%0d, expected 0 0", x, y); end
        checks++; if ({hs, vs} !== 2'b11) begin errors++; $display("FAIL reset_sync: got hs,vs=%b, expected 11", {hs, vs}); end
        checks++; if (active !== 1'b0 || rgb !== 6'h00) begin errors++; $display("FAIL reset_pixel: got active=%b rgb=%h, expected 0 00", active, rgb); end
        checks++; if (frame_start !== 1'b0 || frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame: got fs=%b cnt=%0d, expected 0 0", frame_start, frame_cnt); end
        checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", cfg_if.cfg_ready); end
        checks++; if ({hs_w, vs_w} !== 2'b00) begin errors++; $display("FAIL reset_sync_pol1: got hs,vs=%b, expected 00", {hs_w, vs_w}); end
        rst = 1'b0; rst_w = 1'b0;
        $display("reset released");
    endtask

    task automatic test_frame();
        int p, xx, yy, hs_low, vs_low, act_n, bad, fs_n, fs_at;
        logic e_vis, e_hs, e_vs;
        logic [5:0] rgb0;
        hs_low = 0; vs_low = 0; act_n = 0; bad = 0; fs_n = 0; fs_at = -1; rgb0 = 6'h00;
        repeat (FRAME) begin
            @(negedge clk);
            p  = cyc - 1;
            xx = p % H_TOTAL;
            yy = p / H_TOTAL;
            e_vis = (xx < H_ACTIVE) && (yy < V_ACTIVE);
            e_hs  = !((xx >= H_ACTIVE + H_FP) && (xx < H_ACTIVE + H_FP + H_SYNC));
            e_vs  = !((yy >= V_ACTIVE + V_FP) && (yy < V_ACTIVE + V_FP + V_SYNC));
            if (!hs) hs_low++;
            if (!vs) vs_low++;
            if (active) act_n++;
            if (hs !== e_hs || vs !== e_vs || active !== e_vis || rgb !== (e_vis ? 6'h3F : 6'h00)) bad++;
            if (x !== 10'((cyc % FRAME) % H_TOTAL) || y !== 10'((cyc % FRAME) / H_TOTAL)) bad++;
            if (p == 0) rgb0 = rgb;
            if (frame_start) begin fs_n++; fs_at = cyc; end
        end
        checks++; if (hs_low !== H_SYNC * V_TOTAL) begin errors++; $display("FAIL frame_hs_low: got %0d clks, expected %0d", hs_low, H_SYNC * V_TOTAL); end
        checks++; if (vs_low !== H_TOTAL * V_SYNC) begin errors++; $display("FAIL frame_vs_low: got %0d clks, expected %0d", vs_low, H_TOTAL * V_SYNC); end
        checks++; if (act_n !== H_ACTIVE * V_ACTIVE) begin errors++; $display("FAIL frame_active: got %0d clks, expected %0d", act_n, H_ACTIVE * V_ACTIVE); end
        checks++; if (rgb0 !== 6'h3F) begin errors++; $display("FAIL frame_first_pixel: got %h, expected 3f", rgb0); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL frame_per_clk: got %0d bad clks, expected 0", bad); end
        checks++; if (fs_n !== 1 || fs_at !== FRAME) begin errors++; $display("FAIL frame_start: got %0d pulses at %0d, expected 1 at %0d", fs_n, fs_at, FRAME); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL frame_cnt: got %0d, expected 1", frame_cnt); end
        $display("frame 0 scanned");
    endtask

    task automatic test_cfg_update();
        goto_phase(100);
        offer(32'h409C_6000);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL upd_ready_drop: got %b, expected 0", cfg_if.cfg_ready); end
        checks++; if (rgb !== 6'h3F) begin errors++; $display("FAIL upd_rgb_after_accept: got %h, expected 3f", rgb); end
        goto_phase(H_TOTAL + H_ACTIVE);
        checks++; if (rgb !== 6'h3F || cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL upd_before_commit: got rgb=%h ready=%b, expected 3f 0", rgb, cfg_if.cfg_ready); end
        goto_phase(0);
        checks++; if (frame_start !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL upd_commit: got fs=%b ready=%b, expected 1 1", frame_start, cfg_if.cfg_ready); end
        @(negedge clk);
        checks++; if (rgb !== 6'h2D) begin errors++; $display("FAIL upd_new_pixel: got %h, expected 2d", rgb); end
        checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL upd_frame_cnt: got %0d, expected 2", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        goto_phase(300);
        offer(32'h4FFF_F000);
        @(negedge clk);
        checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_first_accept: got ready=%b, expected 0", cfg_if.cfg_ready); end
        offer(32'hC000_0000);
        goto_phase(H_TOTAL + H_ACTIVE);
        checks++; if (cfg_if.cfg_ready !== 1'b0 || rgb !== 6'h2D) begin errors++; $display("FAIL b2b_held: got ready=%b rgb=%h, expected 0 2d", cfg_if.cfg_ready, rgb); end
        goto_phase(0);
        checks++; if (cfg_if.cfg_ready !== 1'b1 || frame_start !== 1'b1) begin errors++; $display("FAIL b2b_first_commit: got ready=%b fs=%b, expected 1 1", cfg_if.cfg_ready, frame_start); end
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        checks++; if (rgb !== 6'h3F) begin errors++; $display("FAIL b2b_first_active: got %h, expected 3f", rgb); end
        checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got ready=%b, expected 0", cfg_if.cfg_ready); end
    endtask

    task automatic test_bars();
        int          bx [8] = '{0, 63, 64, 200, 448, 511, 520, H_TOTAL + 64};
        logic [5:0]  be [8] = '{6'h00, 6'h00, 6'h03, 6'h0F, 6'h3F, 6'h3F, 6'h00, 6'h03};
        for (int i = 0; i < 8; i++) begin
            goto_phase(bx[i] + 1);
            checks++;
            if (rgb !== be[i]) begin errors++; $display("FAIL bars_pos%0d: got %h, expected %h", bx[i], rgb, be[i]); end
        end
        $display("bars pattern sampled");
    endtask

    task automatic test_noise();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        goto_phase(10);
        offer(32'h0000_0000);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        goto_phase(FRAME - 1);
        goto_phase(1);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (rgb !== lfsr_prev[5:0]) begin errors++; $display("FAIL noise_px%0d: got %h, expected %h", i, rgb, lfsr_prev[5:0]); end
            @(negedge clk);
        end
        $display("noise pixels compared");
    endtask

    task automatic test_reset_midframe();
        goto_phase(200);
        offer(32'h409C_6000);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pending: got ready=%b, expected 0", cfg_if.cfg_ready); end
        goto_phase(700);
        checks++; if (active !== 1'b1 || frame_cnt !== 8'd1) begin errors++; $display("FAIL mid_pre_reset: got active=%b cnt=%0d, expected 1 1", active, frame_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (x !== 10'd0 || y !== 10'd0 || {hs, vs} !== 2'b11) begin errors++; $display("FAIL mid_async_pos: got x=%0d y=%0d hs,vs=%b, expected 0 0 11", x, y, {hs, vs}); end
        checks++; if (active !== 1'b0 || rgb !== 6'h00 || frame_cnt !== 8'd0 || cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_async_state: got active=%b rgb=%h cnt=%0d ready=%b, expected 0 00 0 1", active, rgb, frame_cnt, cfg_if.cfg_ready); end
        @(negedge clk);
        rst = 1'b0;
        goto_phase(1);
        goto_phase(1);
        checks++; if (rgb !== 6'h3F) begin errors++; $display("FAIL mid_word_lost: got %h, expected 3f", rgb); end
        checks++; if (frame_cnt !== 8'd1 || cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_after: got cnt=%0d ready=%b, expected 1 1", frame_cnt, cfg_if.cfg_ready); end
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        while (frame_cnt_w !== 8'd255 && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (frame_cnt_w !== 8'd255) begin errors++; $display("FAIL wrap_reach255: got %0d, expected 255", frame_cnt_w); end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (frame_start_w !== 1'b1 && guard < 300);
        checks++; if (frame_start_w !== 1'b1 || frame_cnt_w !== 8'd0) begin errors++; $display("FAIL wrap_to0: got fs=%b cnt=%0d, expected 1 0", frame_start_w, frame_cnt_w); end
        $display("frame counter wrap observed");
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        pixel_mask = 1'b1; pixel_mask_w = 1'b0;
        cfg_if.cfg_valid = 1'b0;   cfg_if.cfg_data = '0;
        cfg_if_w.cfg_valid = 1'b0; cfg_if_w.cfg_data = '0;
        test_reset();
        test_frame();
        test_cfg_update();
        test_back_to_back();
        test_bars();
        test_noise();
        test_reset_midframe();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
